// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Two-requester arbiter feeding a single UART transmitter through a one-byte
// output buffer. Requesters are granted in IDLE (round-robin pointer breaks
// ties); each accepted byte is counted per requester.
//
// Configuration macro: UART_TX_ARB_LOCK_EN
//   defined   : a grant is held across bytes until a last-byte fire, or until
//               the owner has been idle for LOCK_TIMEOUT cycles.
//   undefined : per-byte round robin; reqN_last is ignored, no idle counter.
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   reqN_data/valid/last      : requester N byte stream (N = 0, 1)
//   reqN_ready                : requester N byte accepted this cycle
//   tx_data/tx_data_valid     : output buffer towards the UART transmitter
//   tx_data_ready             : UART transmitter can take a byte
//   grant                     : one-hot owner {GRANT1, GRANT0}, 00 when idle
//   req0_count/req1_count     : bytes forwarded per requester (wrapping)
module uart_tx_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  req0_data,
    input  logic        req0_valid,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic [7:0]  req1_data,
    input  logic        req1_valid,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic [1:0]  grant,
    output logic [15:0] req0_count,
    output logic [15:0] req1_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   prio, prio_nxt;
    logic   fire0, fire1, xfer;
    logic   release0, release1;

    // Ready depends only on registered state and the buffer, never on valid.
    assign req0_ready = (state == GRANT0) && !tx_data_valid;
    assign req1_ready = (state == GRANT1) && !tx_data_valid;
    assign fire0      = req0_valid && req0_ready;
    assign fire1      = req1_valid && req1_ready;
    assign xfer       = tx_data_valid && tx_data_ready;
    assign grant      = {state == GRANT1, state == GRANT0};

`ifdef UART_TX_ARB_LOCK_EN
    localparam int unsigned CW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CW-1:0] IDLE_LIMIT = CW'(LOCK_TIMEOUT - 1);

    logic [CW-1:0] idle_cnt;
    logic          timeout0, timeout1;

    assign timeout0 = (state == GRANT0) && !req0_valid && (idle_cnt == IDLE_LIMIT);
    assign timeout1 = (state == GRANT1) && !req1_valid && (idle_cnt == IDLE_LIMIT);

    // A fire always wins over an expiring counter in the same cycle.
    assign release0 = fire0 ? req0_last : timeout0;
    assign release1 = fire1 ? req1_last : timeout1;

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (fire0 || fire1 || (state_nxt != state)) begin
            idle_cnt <= '0;
        end else if ((state == GRANT0 && !req0_valid) ||
                     (state == GRANT1 && !req1_valid)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = req0_last ^ req1_last;
    assign release0    = fire0;
    assign release1    = fire1;
`endif

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_nxt = prio ? GRANT1 : GRANT0;
                end else if (req0_valid) begin
                    state_nxt = GRANT0;
                end else if (req1_valid) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (release0) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b1;
                end
            end
            GRANT1: begin
                if (release1) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    // A fire needs an empty buffer, so fire and output transfer never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            req0_count    <= '0;
            req1_count    <= '0;
        end else if (fire0) begin
            tx_data       <= req0_data;
            tx_data_valid <= 1'b1;
            req0_count    <= req0_count + 16'd1;
        end else if (fire1) begin
            tx_data       <= req1_data;
            tx_data_valid <= 1'b1;
            req1_count    <= req1_count + 16'd1;
        end else if (xfer) begin
            tx_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte-order scoreboard.
// Covers UART_TX_ARB_LOCK_EN both defined and undefined.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req0_data, req1_data;
    logic        req0_valid, req0_last, req0_ready;
    logic        req1_valid, req1_last, req1_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid, tx_data_ready;
    logic [1:0]  grant;
    logic [15:0] req0_count, req1_count;

    uart_tx_arbiter #(.LOCK_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .grant(grant), .req0_count(req0_count), .req1_count(req1_count)
    );

    always #5 clk = ~clk;

    item_t      src0[$];
    item_t      src1[$];
    logic [7:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic       f0, f1, xf;
    logic [7:0] xd;
    logic [1:0] prev_grant = 2'b00;
    logic       bad_trans = 1'b0;
    logic       g1_early = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = (src0.size() > 0);
        req1_valid = (src1.size() > 0);
        if (src0.size() > 0) begin
            req0_data = src0[0].data;
            req0_last = src0[0].last;
        end else begin
            req0_data = '0;
            req0_last = 1'b0;
        end
        if (src1.size() > 0) begin
            req1_data = src1[0].data;
            req1_last = src1[0].last;
        end else begin
            req1_data = '0;
            req1_last = 1'b0;
        end
    endtask

    // One clock: sample handshakes at the edge, then update sources/scoreboard.
    task automatic step();
        @(posedge clk);
        f0 = req0_valid && req0_ready;
        f1 = req1_valid && req1_ready;
        xf = tx_data_valid && tx_data_ready;
        xd = tx_data;
        #1;
        if (xf) begin
            if (exp_q.size() == 0) check("tx_extra_byte", 32'(exp_q.size()), 1);
            else check("tx_order", xd, exp_q.pop_front());
        end
        if (f0 && src0.size() > 0) void'(src0.pop_front());
        if (f1 && src1.size() > 0) void'(src1.pop_front());
        if ((prev_grant == 2'b01 && grant == 2'b10) || (prev_grant == 2'b10 && grant == 2'b01))
            bad_trans = 1'b1;
        if (grant == 2'b10 && src0.size() > 0) g1_early = 1'b1;
        prev_grant = grant;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src0.delete();
        src1.delete();
        exp_q.delete();
        drive();
        step();
        step();
        reset = 1'b0;
        prev_grant = 2'b00;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0) break;
            step();
        end
        check(tag, 32'(exp_q.size() + src0.size() + src1.size()), 0);
    endtask

    initial begin
        tx_data_ready = 1'b1;
        drive();
        do_reset();

        // Reset state
        check("rst_grant", grant, 2'b00);
        check("rst_valid", tx_data_valid, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_cnt0", req0_count, 0);
        check("rst_cnt1", req1_count, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);

        // Single byte latency: valid at N, grant N+1, tx valid N+2
        src0.push_back({8'h41, 1'b1});
        exp_q.push_back(8'h41);
        drive();
        step();
        check("lat_grant", grant, 2'b01);
        check("lat_ready0", req0_ready, 1);
        check("lat_nobuf", tx_data_valid, 0);
        step();
        check("lat_valid", tx_data_valid, 1);
        check("lat_data", tx_data, 8'h41);
        check("lat_cnt0", req0_count, 1);
        check("lat_release", grant, 2'b00);
        step();
        check("lat_xfer_clear", tx_data_valid, 0);
        check("lat_sb_empty", 32'(exp_q.size()), 0);

`ifdef UART_TX_ARB_LOCK_EN
        // Locked message: three req0 bytes precede the req1 byte
        do_reset();
        src0.push_back({8'h31, 1'b0});
        src0.push_back({8'h32, 1'b0});
        src0.push_back({8'h33, 1'b1});
        src1.push_back({8'h55, 1'b1});
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h55);
        g1_early = 1'b0;
        drive();
        wait_drain("lock_drain", 60);
        check("lock_no_g1_mid", g1_early, 0);
        check("lock_cnt0", req0_count, 3);
        check("lock_cnt1", req1_count, 1);

        // Timeout: owner goes quiet after a non-last byte
        do_reset();
        src0.push_back({8'h61, 1'b0});
        src1.push_back({8'h62, 1'b1});
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        drive();
        f0 = 1'b0;
        for (int i = 0; i < 10 && !f0; i++) step();
        check("to_fire", f0, 1);
        repeat (7) step();
        check("to_hold", grant, 2'b01);
        step();
        check("to_release", grant, 2'b00);
        step();
        check("to_next", grant, 2'b10);
        wait_drain("to_drain", 20);
`else
        // Per-byte round robin with both requesters continuously valid
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src0.push_back({8'(8'h10 + i), 1'b0});
            src1.push_back({8'(8'h20 + i), 1'b0});
            exp_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h20 + i));
        end
        drive();
        wait_drain("rr_drain", 60);
        check("rr_cnt0", req0_count, 4);
        check("rr_cnt1", req1_count, 4);
`endif
        check("no_direct_switch", bad_trans, 0);

        // Transmitter stall holds the buffered byte and blocks further fires
        do_reset();
        tx_data_ready = 1'b0;
        src0.push_back({8'hA1, 1'b1});
        src0.push_back({8'hA2, 1'b1});
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        drive();
        for (int i = 0; i < 10 && !tx_data_valid; i++) step();
        for (int i = 0; i < 20; i++) begin
            check("stall_data", tx_data, 8'hA1);
            check("stall_valid", tx_data_valid, 1);
            check("stall_ready0", req0_ready, 0);
            check("stall_cnt0", req0_count, 1);
            step();
        end
        tx_data_ready = 1'b1;
        step();
        check("stall_single_xfer", tx_data_valid, 0);
        check("stall_sb_one_left", 32'(exp_q.size()), 1);
        wait_drain("stall_drain", 20);
        check("stall_cnt0_final", req0_count, 2);

        // Reset while GRANT0 holds a buffered byte
        do_reset();
        tx_data_ready = 1'b0;
        src0.push_back({8'h71, 1'b0});
        src0.push_back({8'h72, 1'b0});
        drive();
        for (int i = 0; i < 10 && !(tx_data_valid && grant == 2'b01); i++) step();
        check("mid_pre_valid", tx_data_valid, 1);
        check("mid_pre_grant", grant, 2'b01);
        check("mid_pre_cnt0", req0_count, 1);
        reset = 1'b1;
        src0.delete();
        drive();
        step();
        reset = 1'b0;
        check("mid_valid", tx_data_valid, 0);
        check("mid_grant", grant, 2'b00);
        check("mid_data", tx_data, 8'h00);
        check("mid_cnt0", req0_count, 0);
        check("mid_cnt1", req1_count, 0);
        tx_data_ready = 1'b1;
        repeat (3) step();
        check("mid_quiet", tx_data_valid, 0);
        check("final_sb_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
